mvm_csr_feeder: RTL and testbench
=================================

# mvm_csr_feeder

Upstream stage of the MVM accelerator. Accepts a dense 3x3 8-bit matrix and a 3-bit spike train from the host as a byte stream and compresses the matrix into row-major CSR triples (row, column, value), dropping zero entries. It then drives the accelerator's load handshake: start pulse, one pulse per triple, done_list, and finally the spike train. It holds off the next frame until the accelerator has returned to idle.

## Interface
Parameters:
- ROWS, 3, matrix rows (1..3; row index is 2 bits)
- COLS, 3, matrix columns (1..3; column index is 2 bits)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- host_valid  in  1  host byte valid
- host_data  in  8  matrix byte (bytes 0..ROWS*COLS-1, row-major), then spike byte
- host_ready  out  1  feeder accepts a byte this cycle
- mvm_start  out  1  one-cycle start pulse to the accelerator
- mvm_sending_cpu  out  1  one-cycle data-valid pulse to the accelerator
- mvm_done_list  out  1  one-cycle end-of-CSR pulse
- mvm_row_val  out  2  CSR row index
- mvm_column_val  out  2  CSR column index
- mvm_value  out  8  CSR value, or spike train in bits [2:0] with bits [7:3] = 0
- mvm_fetch_ready  in  1  accelerator FETCH_ready
- busy  out  1  high in any state other than LOAD
- nnz_count  out  4  number of triples buffered for the current frame

## Operation
- Reset: state = LOAD. All outputs are 0 except host_ready = 1. Buffer, nnz_count, counters and the arm flag are cleared. A reset mid-frame discards the frame.
- LOAD: host_ready = 1, combinational from state.
  - Each accepted byte (host_valid && host_ready) advances the (r, c) counters in row-major order. c wraps at COLS-1 and r then increments.
  - With zero-skip enabled, a zero byte is dropped. Otherwise {r, c, byte} is written to buffer[nnz_count] and nnz_count increments.
  - Byte index ROWS*COLS is the spike byte. Bits [2:0] are latched, and the state goes to START on the next cycle.
  - host_valid is ignored outside LOAD.
- START: assert mvm_start for exactly 1 cycle and clear the arm flag. Next state is SEND_CSR, or SEND_DONE if nnz_count = 0.
- Pulse rule, applied to every sending_cpu and done_list pulse:
  - The arm flag is set when mvm_fetch_ready is sampled 0.
  - A pulse is issued only in a cycle where the flag is set and mvm_fetch_ready = 1.
  - Issuing a pulse clears the flag.
  - This guarantees one transfer per accelerator ready window.
- SEND_CSR: for each pulse, drive buffer[k] on row/column/value in the same cycle as mvm_sending_cpu = 1, then increment k. After k reaches nnz_count-1 and its pulse is sent, go to SEND_DONE.
- SEND_DONE: one mvm_done_list pulse under the pulse rule, then go to SEND_TRAIN.
- SEND_TRAIN: one mvm_sending_cpu pulse with mvm_value = {5'b0, spike}, then go to WAIT_IDLE.
- WAIT_IDLE: wait until mvm_fetch_ready is sampled 0 (accelerator back in IDLE). Then clear nnz_count, k and the counters, and go to LOAD.
- Data outputs hold their last value between pulses.

## Timing
- The host cannot overrun the feeder: the first byte of the next frame is accepted in the first LOAD cycle after WAIT_IDLE.
- LOAD → START happens 1 cycle after the spike byte is accepted.
- mvm_start → first sending_cpu pulse takes 2 cycles against a compliant accelerator: fetch_ready is 0 in its IDLE and rises 1 cycle after start.
- Successive sending_cpu pulses are ≥2 cycles apart: the accelerator drops fetch_ready for 1 cycle after each accept.
- No output pulse is ever longer than 1 cycle. mvm_start, mvm_sending_cpu and mvm_done_list are mutually exclusive in every cycle.
- Boundary cases:
  - All-zero matrix (nnz_count = 0): START → SEND_DONE directly.
  - Full matrix: nnz_count = 9, the buffer is full, and no overflow is possible.
  - A fetch_ready already high when a SEND state is entered does not trigger a pulse until it has been seen low (arm flag cleared at START).

## Configuration
- CSR_ZERO_SKIP_EN defined: zero bytes are not buffered or sent, and nnz_count ≤ ROWS*COLS.
- CSR_ZERO_SKIP_EN undefined: every byte is buffered and sent, including zeros, and nnz_count = ROWS*COLS always.
- Handshake and timing are otherwise identical in both builds.

## Structure
- Shared package mvm_pkg holds:
  - state enum (LOAD, START, SEND_CSR, SEND_DONE, SEND_TRAIN, WAIT_IDLE)
  - csr_entry_t struct {row[1:0], col[1:0], val[7:0]}
  - MAX_NNZ = 9
  - index widths
- One sub-module is natural: mvm_pulse_gate (arm flag plus pulse-issue logic), instantiated once and shared by SEND_CSR, SEND_DONE and SEND_TRAIN.

## Test plan
Each scenario runs against a behavioural accelerator model.
- Identity matrix (1,0,0 / 0,1,0 / 0,0,1), spike 3'b101, skip enabled:
  - nnz_count = 3.
  - Triples sent are (0,0,1), (1,1,1), (2,2,1), then done_list, then value = 8'h05.
- Same matrix, skip disabled: 9 triples in row-major order, zeros included.
- All-zero matrix, skip enabled: mvm_start, then done_list with no data pulses, then spike.
- Full matrix of values 1..9, fetch_ready model held low for 5 extra cycles before each window:
  - 9 pulses, each exactly 1 cycle.
  - No pulse while fetch_ready = 0.
  - Values arrive in order.
- host_valid held high across the whole frame: exactly 10 bytes accepted. host_ready = 0 through WAIT_IDLE and returns to 1 only after fetch_ready drops.
- rst_n asserted during SEND_CSR after 2 pulses:
  - All outputs 0 and host_ready = 1 immediately.
  - The next frame starts from byte 0 with nnz_count = 0.

Source files
------------

// File: rtl/mvm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mvm_pkg
// Description : Shared types and sizes for the MVM CSR feeder: feeder state
//               encoding, CSR triple layout and buffer dimensions.
// Revision    : 1.0 - initial release
// ============================================================================
package mvm_pkg;

   localparam int MAX_NNZ = 9;   // 3x3 matrix, every entry may be non-zero
   localparam int NNZ_W   = 4;   // holds 0..MAX_NNZ
   localparam int IDX_W   = 2;   // row / column index width
   localparam int DATA_W  = 8;   // matrix element / host byte width
   localparam int SPIKE_W = 3;   // spike train width

   typedef enum logic [2:0] {
      LOAD       = 3'd0,
      START      = 3'd1,
      SEND_CSR   = 3'd2,
      SEND_DONE  = 3'd3,
      SEND_TRAIN = 3'd4,
      WAIT_IDLE  = 3'd5
   } state_t;

   typedef struct packed {
      logic [IDX_W-1:0]  row;
      logic [IDX_W-1:0]  col;
      logic [DATA_W-1:0] val;
   } csr_entry_t;

endpackage
`default_nettype wire

// File: rtl/mvm_pulse_gate.sv
`default_nettype none
// ============================================================================
// Module      : mvm_pulse_gate
// Description : One-transfer-per-ready-window gate. An arm flag is set when
//               fetch_ready is seen low; a pulse may only fire while armed and
//               fetch_ready is high, and firing disarms the gate.
// Revision    : 1.0 - initial release
// ============================================================================
module mvm_pulse_gate (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_arm,    // forced disarm (frame start)
   input  logic enable,       // a pulse is wanted this cycle
   input  logic fetch_ready,
   output logic fire
);

   logic arm_q;
   logic arm_d;

   // Fire decision and arm-flag next value; disarm has priority over re-arm
   always_comb begin
      fire  = enable & arm_q & fetch_ready;
      arm_d = arm_q;
      if (clear_arm) begin
         arm_d = 1'b0;
      end else if (fire) begin
         arm_d = 1'b0;
      end else if (!fetch_ready) begin
         arm_d = 1'b1;
      end
   end

   // Arm flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arm_q <= 1'b0;
      end else begin
         arm_q <= arm_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mvm_csr_feeder.sv
`default_nettype none
// ============================================================================
// Module      : mvm_csr_feeder
// Description : Accepts a dense ROWSxCOLS byte matrix plus a spike byte from
//               the host, buffers it as row-major CSR triples and replays the
//               accelerator load handshake (start, triples, done_list, spike).
//               Build option CSR_ZERO_SKIP_EN: when defined, zero matrix bytes
//               are dropped instead of buffered and sent.
// Revision    : 1.0 - initial release
// ============================================================================
module mvm_csr_feeder
   import mvm_pkg::*;
#(
   parameter int ROWS = 3,
   parameter int COLS = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              host_valid,
   input  logic [DATA_W-1:0] host_data,
   output logic              host_ready,
   output logic              mvm_start,
   output logic              mvm_sending_cpu,
   output logic              mvm_done_list,
   output logic [IDX_W-1:0]  mvm_row_val,
   output logic [IDX_W-1:0]  mvm_column_val,
   output logic [DATA_W-1:0] mvm_value,
   input  logic              mvm_fetch_ready,
   output logic              busy,
   output logic [NNZ_W-1:0]  nnz_count
);

   // Row counter reaching ROWS marks the spike byte
   localparam logic [IDX_W-1:0] ROW_END  = IDX_W'(ROWS);
   localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(COLS - 1);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     r_q, r_d;
   logic [IDX_W-1:0]     c_q, c_d;
   logic [NNZ_W-1:0]     nnz_q, nnz_d;
   logic [NNZ_W-1:0]     k_q, k_d;
   logic [SPIKE_W-1:0]   spike_q, spike_d;
   csr_entry_t           buf_q [MAX_NNZ];
   csr_entry_t           buf_d [MAX_NNZ];
   csr_entry_t           out_q, out_d;
   csr_entry_t           rd_entry;
   logic                 skip_byte;
   logic                 gate_en;
   logic                 clear_arm;
   logic                 fire;

`ifdef CSR_ZERO_SKIP_EN
   assign skip_byte = (host_data == '0);
`else
   assign skip_byte = 1'b0;
`endif

   // Gate controls depend on state only, keeping fire free of feedback
   assign gate_en   = (state_q == SEND_CSR) || (state_q == SEND_DONE) ||
                      (state_q == SEND_TRAIN);
   assign clear_arm = (state_q == START);

   mvm_pulse_gate u_pulse_gate (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_arm   (clear_arm),
      .enable      (gate_en),
      .fetch_ready (mvm_fetch_ready),
      .fire        (fire)
   );

   // Select buffer entry k for the next CSR transfer
   always_comb begin
      rd_entry = '0;
      for (int i = 0; i < MAX_NNZ; i++) begin
         if (k_q == NNZ_W'(i)) begin
            rd_entry = buf_q[i];
         end
      end
   end

   // Next-state, buffer write and handshake outputs
   always_comb begin
      state_d         = state_q;
      r_d             = r_q;
      c_d             = c_q;
      nnz_d           = nnz_q;
      k_d             = k_q;
      spike_d         = spike_q;
      buf_d           = buf_q;
      out_d           = out_q;
      host_ready      = 1'b0;
      mvm_start       = 1'b0;
      mvm_sending_cpu = 1'b0;
      mvm_done_list   = 1'b0;

      case (state_q)
         LOAD: begin
            host_ready = 1'b1;
            if (host_valid) begin
               if (r_q == ROW_END) begin
                  spike_d = host_data[SPIKE_W-1:0];
                  state_d = START;
               end else begin
                  if (!skip_byte) begin
                     for (int i = 0; i < MAX_NNZ; i++) begin
                        if (nnz_q == NNZ_W'(i)) begin
                           buf_d[i].row = r_q;
                           buf_d[i].col = c_q;
                           buf_d[i].val = host_data;
                        end
                     end
                     nnz_d = nnz_q + NNZ_W'(1);
                  end
                  if (c_q == COL_LAST) begin
                     c_d = '0;
                     r_d = r_q + IDX_W'(1);
                  end else begin
                     c_d = c_q + IDX_W'(1);
                  end
               end
            end
         end

         START: begin
            mvm_start = 1'b1;
            state_d   = (nnz_q == '0) ? SEND_DONE : SEND_CSR;
         end

         SEND_CSR: begin
            if (fire) begin
               mvm_sending_cpu = 1'b1;
               out_d           = rd_entry;
               if (k_q == nnz_q - NNZ_W'(1)) begin
                  state_d = SEND_DONE;
               end else begin
                  k_d = k_q + NNZ_W'(1);
               end
            end
         end

         SEND_DONE: begin
            if (fire) begin
               mvm_done_list = 1'b1;
               state_d       = SEND_TRAIN;
            end
         end

         SEND_TRAIN: begin
            if (fire) begin
               mvm_sending_cpu = 1'b1;
               out_d.val       = {{(DATA_W-SPIKE_W){1'b0}}, spike_q};
               state_d         = WAIT_IDLE;
            end
         end

         WAIT_IDLE: begin
            // Accelerator back in IDLE once fetch_ready is seen low
            if (!mvm_fetch_ready) begin
               nnz_d   = '0;
               k_d     = '0;
               r_d     = '0;
               c_d     = '0;
               state_d = LOAD;
            end
         end

         default: begin
            state_d = LOAD;
         end
      endcase
   end

   // Data outputs show the new triple in its pulse cycle and hold afterwards
   assign mvm_row_val    = out_d.row;
   assign mvm_column_val = out_d.col;
   assign mvm_value      = out_d.val;
   assign busy           = (state_q != LOAD);
   assign nnz_count      = nnz_q;

   // State, counters, buffer and held outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOAD;
         r_q     <= '0;
         c_q     <= '0;
         nnz_q   <= '0;
         k_q     <= '0;
         spike_q <= '0;
         out_q   <= '0;
         for (int i = 0; i < MAX_NNZ; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         c_q     <= c_d;
         nnz_q   <= nnz_d;
         k_q     <= k_d;
         spike_q <= spike_d;
         out_q   <= out_d;
         for (int i = 0; i < MAX_NNZ; i++) begin
            buf_q[i] <= buf_d[i];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mvm_csr_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mvm_csr_feeder
// Description : Directed bench for mvm_csr_feeder with a behavioural
//               accelerator; expectations follow CSR_ZERO_SKIP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mvm_csr_feeder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       host_valid;
   logic [7:0] host_data;
   logic       host_ready;
   logic       mvm_start;
   logic       mvm_sending_cpu;
   logic       mvm_done_list;
   logic [1:0] mvm_row_val;
   logic [1:0] mvm_column_val;
   logic [7:0] mvm_value;
   logic       fr;
   logic       busy;
   logic [3:0] nnz_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mvm_csr_feeder #(.ROWS(3), .COLS(3)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .host_valid      (host_valid),
      .host_data       (host_data),
      .host_ready      (host_ready),
      .mvm_start       (mvm_start),
      .mvm_sending_cpu (mvm_sending_cpu),
      .mvm_done_list   (mvm_done_list),
      .mvm_row_val     (mvm_row_val),
      .mvm_column_val  (mvm_column_val),
      .mvm_value       (mvm_value),
      .mvm_fetch_ready (fr),
      .busy            (busy),
      .nnz_count       (nnz_count)
   );

   // Behavioural accelerator: IDLE(fr=0) -> WAITR(fr=0, 1+extra cycles) ->
   // READY(fr=1); every accepted pulse drops fr again; the pulse after
   // done_list returns it to IDLE.
   int   extra = 0;
   int   am_st;
   int   am_cnt;
   logic got_done;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         am_st <= 0; fr <= 1'b0; am_cnt <= 0; got_done <= 1'b0;
      end else begin
         case (am_st)
            0: if (mvm_start) begin am_st <= 1; am_cnt <= extra; got_done <= 1'b0; end
            1: if (am_cnt == 0) begin am_st <= 2; fr <= 1'b1; end
               else am_cnt <= am_cnt - 1;
            default: begin
               if (mvm_done_list) begin
                  got_done <= 1'b1; am_st <= 1; fr <= 1'b0; am_cnt <= extra;
               end else if (mvm_sending_cpu) begin
                  fr <= 1'b0;
                  if (got_done) am_st <= 0;
                  else begin am_st <= 1; am_cnt <= extra; end
               end
            end
         endcase
      end
   end

   // Cycle counter and event monitor (sampled on the falling edge)
   int         cyc = 0;
   int         ev_kind[$];   // 0 start, 1 sending_cpu, 2 done_list
   logic [1:0] ev_row[$];
   logic [1:0] ev_col[$];
   logic [7:0] ev_val[$];
   int         acc_cnt, spike_cyc, start_cyc, first_cyc, last_cyc, viol, n_data;
   int         nnz_at_start;
   logic       p_start, p_send, p_done;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (host_valid && host_ready) begin
            acc_cnt = acc_cnt + 1;
            if (acc_cnt == 10) spike_cyc = cyc;
         end
         if ((int'(mvm_start) + int'(mvm_sending_cpu) + int'(mvm_done_list)) > 1) viol++;
         if ((mvm_sending_cpu || mvm_done_list) && !fr) viol++;
         if ((mvm_start && p_start) || (mvm_sending_cpu && p_send) || (mvm_done_list && p_done)) viol++;
         if (busy == host_ready) viol++;
         if (mvm_start) begin
            ev_kind.push_back(0); ev_row.push_back(2'd0); ev_col.push_back(2'd0); ev_val.push_back(8'd0);
            start_cyc = cyc; nnz_at_start = int'(nnz_count);
         end
         if (mvm_sending_cpu || mvm_done_list) begin
            ev_kind.push_back(mvm_done_list ? 2 : 1);
            ev_row.push_back(mvm_row_val); ev_col.push_back(mvm_column_val); ev_val.push_back(mvm_value);
            if (mvm_sending_cpu) n_data++;
            if (first_cyc < 0) first_cyc = cyc;
            if (last_cyc >= 0 && (cyc - last_cyc) < 2) viol++;
            last_cyc = cyc;
         end
         p_start = mvm_start; p_send = mvm_sending_cpu; p_done = mvm_done_list;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      ev_kind.delete(); ev_row.delete(); ev_col.delete(); ev_val.delete();
      acc_cnt = 0; spike_cyc = -100; start_cyc = -100; first_cyc = -1; last_cyc = -1;
      viol = 0; n_data = 0; nnz_at_start = -1;
      p_start = 1'b0; p_send = 1'b0; p_done = 1'b0;
   endtask

   // Offer 10 bytes back to back, then keep host_valid high with filler
   task automatic send_frame(input logic [71:0] mat, input logic [7:0] sbyte);
      for (int i = 0; i < 10; i++) begin
         int t;
         host_valid = 1'b1;
         host_data  = (i < 9) ? mat[8*i +: 8] : sbyte;
         t = 0;
         while (!host_ready && t < 200) begin @(posedge clk); #1; t++; end
         @(posedge clk); #1;
      end
      host_data = 8'hEE;
   endtask

   // Wait until the feeder is back in LOAD, dropping host_valid right away
   task automatic wait_frame(input string tag);
      int t;
      t = 0;
      while (!host_ready && t < 2000) begin @(posedge clk); #1; t++; end
      host_valid = 1'b0;
      chk({tag, "_timeout"}, (t < 2000), 1);
   endtask

   task automatic check_frame(input string tag, input logic [71:0] mat,
                              input logic [7:0] sbyte, input int extra_c);
      int         en;
      logic [1:0] er [9];
      logic [1:0] ec [9];
      logic [7:0] evv[9];
      en = 0;
      for (int i = 0; i < 9; i++) begin
         logic [7:0] b;
         logic       sk;
         b  = mat[8*i +: 8];
         sk = 1'b0;
`ifdef CSR_ZERO_SKIP_EN
         sk = (b == 8'd0);
`endif
         if (!sk) begin
            er[en] = 2'(i / 3); ec[en] = 2'(i % 3); evv[en] = b; en++;
         end
      end
      chk({tag, "_bytes_accepted"}, acc_cnt, 10);
      chk({tag, "_load_to_start"}, start_cyc, spike_cyc + 1);
      chk({tag, "_nnz"}, nnz_at_start, en);
      chk({tag, "_event_count"}, ev_kind.size(), en + 3);
      if (ev_kind.size() > 0) chk({tag, "_ev0_start"}, ev_kind[0], 0);
      for (int j = 0; j < en; j++) begin
         if (1 + j < ev_kind.size()) begin
            chk($sformatf("%s_t%0d_kind", tag, j), ev_kind[1+j], 1);
            chk($sformatf("%s_t%0d_row", tag, j), ev_row[1+j], er[j]);
            chk($sformatf("%s_t%0d_col", tag, j), ev_col[1+j], ec[j]);
            chk($sformatf("%s_t%0d_val", tag, j), ev_val[1+j], evv[j]);
         end
      end
      if (en + 1 < ev_kind.size()) chk({tag, "_done_kind"}, ev_kind[en+1], 2);
      if (en + 2 < ev_kind.size()) begin
         chk({tag, "_train_kind"}, ev_kind[en+2], 1);
         chk({tag, "_train_val"}, ev_val[en+2], {5'b0, sbyte[2:0]});
      end
      chk({tag, "_start_to_first_pulse"}, first_cyc - start_cyc, 2 + extra_c);
      chk({tag, "_protocol_violations"}, viol, 0);
   endtask

   task automatic run_frame(input string tag, input logic [71:0] mat,
                            input logic [7:0] sbyte, input int extra_c);
      clear_log();
      extra = extra_c;
      send_frame(mat, sbyte);
      wait_frame(tag);
      check_frame(tag, mat, sbyte, extra_c);
      @(posedge clk); #1;
   endtask

   localparam logic [71:0] M_IDENT = {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
   localparam logic [71:0] M_ZERO  = 72'd0;
   localparam logic [71:0] M_FULL  = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};

   initial begin
      rst_n = 1'b0; host_valid = 1'b0; host_data = 8'd0;
      clear_log();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_host_ready", host_ready, 1);
      chk("rst_start", mvm_start, 0);
      chk("rst_sending", mvm_sending_cpu, 0);
      chk("rst_done", mvm_done_list, 0);
      chk("rst_value", {mvm_row_val, mvm_column_val, mvm_value}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_nnz", nnz_count, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_frame("ident", M_IDENT, 8'hFD, 0);
      run_frame("zero", M_ZERO, 8'h02, 0);
      run_frame("full_slow", M_FULL, 8'h07, 5);

      // Reset in the middle of SEND_CSR after two data pulses
      begin
         int t;
         clear_log();
         extra = 0;
         send_frame(M_FULL, 8'h01);
         t = 0;
         while (n_data < 2 && t < 200) begin @(posedge clk); #1; t++; end
         chk("midrst_reached_two_pulses", n_data, 2);
         rst_n = 1'b0;
         #1;
         chk("midrst_host_ready", host_ready, 1);
         chk("midrst_start", mvm_start, 0);
         chk("midrst_sending", mvm_sending_cpu, 0);
         chk("midrst_done", mvm_done_list, 0);
         chk("midrst_data", {mvm_row_val, mvm_column_val, mvm_value}, 0);
         chk("midrst_busy", busy, 0);
         chk("midrst_nnz", nnz_count, 0);
         host_valid = 1'b0;
         @(posedge clk); #1;
         rst_n = 1'b1;
         @(posedge clk); #1;
         chk("postrst_nnz", nnz_count, 0);
         chk("postrst_host_ready", host_ready, 1);
      end

      run_frame("ident_after_rst", M_IDENT, 8'h03, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: observed no end of test, expected summary before 300us");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
